// File: rtl/aes_pkg.sv
// Shared Rijndael helpers for the round datapath.
//   AES_NB      : column count of the AES state
//   MAX_NB      : widest supported Rijndael state (8 columns)
//   shift_off() : ShiftRows offset of a given row for a given column count
//   shift_rows(): ShiftRows / InvShiftRows as a pure byte permutation on a
//                 left-justified MAX_STATE_W-bit state (byte k at bits [8k:8k+7])
package aes_pkg;

    localparam int unsigned AES_NB      = 4;
    localparam int unsigned MAX_NB      = 8;
    localparam int unsigned MAX_STATE_W = 32 * MAX_NB;

    // Rows 2 and 3 shift one further for 8-column states.
    function automatic int unsigned shift_off(input int unsigned nb, input int unsigned row);
        if (nb == 8 && row >= 2) begin
            return row + 1;
        end
        return row;
    endfunction

    // Every output byte is a fixed source byte for a given nb; inv only selects
    // between two permutations, so this maps to a 2:1 byte mux per position.
    function automatic logic [0:MAX_STATE_W-1] shift_rows(input logic [0:MAX_STATE_W-1] state,
                                                          input int unsigned             nb,
                                                          input logic                    inv);
        logic [0:MAX_STATE_W-1] res;
        int unsigned row;
        int unsigned col;
        int unsigned src;
        res = '0;
        for (int unsigned k = 0; k < 4 * MAX_NB; k++) begin
            if (k < 4 * nb) begin
                row = k % 4;
                col = k / 4;
                if (inv) begin
                    src = (col + nb - shift_off(nb, row)) % nb;
                end else begin
                    src = (col + shift_off(nb, row)) % nb;
                end
                res[8*k +: 8] = state[8*(4*src + row) +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_pipe_stage.sv
// One elastic register stage (valid/ready on both sides).
//   clk, rst_n       : clock, asynchronous active-low reset
//   flush            : synchronous drop of the held transaction
//   up_valid_i/up_ready_o/up_data_i   : upstream side
//   dn_valid_o/dn_ready_i/dn_data_o   : downstream side
// The stage loads whenever it is empty or its content leaves this cycle, so an
// empty stage never blocks upstream even while downstream stalls.
module aes_pipe_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         up_valid_i,
    output logic         up_ready_o,
    input  logic [W-1:0] up_data_i,
    output logic         dn_valid_o,
    input  logic         dn_ready_i,
    output logic [W-1:0] dn_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    assign load       = !valid_q || dn_ready_i;
    assign up_ready_o = load;
    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = up_valid_i;
            // Data only moves with a real transaction; bubbles leave it untouched.
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Pipelined, elastic ShiftRows / InvShiftRows with per-transaction direction.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous clear of every stage; blocks input that cycle
//   in_valid/in_ready     : input handshake; in_inv selects InvShiftRows, in_tag is sideband
//   state_in              : column-major state, byte k at [8k:8k+7]
//   out_valid/out_ready   : output handshake; out_tag / state_out travel together
//   occupancy             : number of stages currently holding a transaction
// The permutation sits in front of stage 1; later stages only carry the result.
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int unsigned NB          = AES_NB,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [0:32*NB-1]   state_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TAG_W-1:0]   out_tag,
    output logic [0:32*NB-1]   state_out,
    output logic [2:0]         occupancy
);

    localparam int unsigned STATE_W = 32 * NB;
    localparam int unsigned W       = STATE_W + TAG_W;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
        $error("aes_shift_rows_pipe: PIPE_STAGES must be 1..4");
    end

    // Permutation on a state padded to the widest Rijndael size.
    logic [0:MAX_STATE_W-1] state_pad;
    logic [0:MAX_STATE_W-1] perm_full;

    always_comb begin
        state_pad              = '0;
        state_pad[0:STATE_W-1] = state_in;
    end

    assign perm_full = shift_rows(state_pad, NB, in_inv);

    if (STATE_W < MAX_STATE_W) begin : g_pad_tail
        logic unused_perm_tail;
        assign unused_perm_tail = ^perm_full[STATE_W:MAX_STATE_W-1];
    end

    // Link k feeds stage k+1; link PIPE_STAGES is the output port.
    logic [W-1:0]         stage_data [PIPE_STAGES+1];
    logic [PIPE_STAGES:0] stage_valid;
    logic [PIPE_STAGES:0] stage_ready;
    logic [PIPE_STAGES-1:0] stage_up_ready;
    logic                 unused_up_ready;

    assign stage_valid[0] = in_valid && !flush;
    assign stage_data[0]  = {in_tag, perm_full[0:STATE_W-1]};

    // Ready chain computed in one place from the valid bits so the
    // out_ready -> in_ready path stays a plain combinational ripple.
    always_comb begin
        stage_ready              = '0;
        stage_ready[PIPE_STAGES] = out_ready;
        for (int k = int'(PIPE_STAGES); k >= 1; k--) begin
            stage_ready[k-1] = !stage_valid[k] || stage_ready[k];
        end
    end

    for (genvar k = 1; k <= PIPE_STAGES; k++) begin : g_stage
        aes_pipe_stage #(
            .W (W)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .up_valid_i (stage_valid[k-1]),
            .up_ready_o (stage_up_ready[k-1]),
            .up_data_i  (stage_data[k-1]),
            .dn_valid_o (stage_valid[k]),
            .dn_ready_i (stage_ready[k]),
            .dn_data_o  (stage_data[k])
        );
    end

    // Each stage reports the same readiness the chain above already derives.
    assign unused_up_ready = ^stage_up_ready;

    assign in_ready  = stage_ready[0] && !flush;
    assign out_valid = stage_valid[PIPE_STAGES];
    assign out_tag   = stage_data[PIPE_STAGES][W-1 -: TAG_W];
    assign state_out = stage_data[PIPE_STAGES][STATE_W-1:0];

    always_comb begin
        occupancy = '0;
        for (int unsigned k = 1; k <= PIPE_STAGES; k++) begin
            occupancy = occupancy + 3'(stage_valid[k]);
        end
    end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Self-checking bench for aes_shift_rows_pipe: matrix-level reference model,
// per-cycle scoreboard, and directed literal vectors.
module tb_aes_shift_rows_pipe;

    localparam int unsigned PS = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         in_inv;
    logic [3:0]   in_tag;
    logic [0:127] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_tag;
    logic [0:127] state_out;
    logic [2:0]   occupancy;

    logic         flush8;
    logic         in_valid8;
    logic         in_ready8;
    logic         in_inv8;
    logic [3:0]   in_tag8;
    logic [0:255] state_in8;
    logic         out_valid8;
    logic         out_ready8;
    logic [3:0]   out_tag8;
    logic [0:255] state_out8;
    logic [2:0]   occupancy8;

    logic drv_ready;
    logic rnd_ready = 1'b1;
    bit   rand_rdy  = 1'b0;
    assign out_ready = rand_rdy ? rnd_ready : drv_ready;

    always #5 clk = ~clk;

    aes_shift_rows_pipe #(.NB(4), .PIPE_STAGES(PS), .TAG_W(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_tag    (in_tag),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .state_out (state_out),
        .occupancy (occupancy)
    );

    aes_shift_rows_pipe #(.NB(8), .PIPE_STAGES(1), .TAG_W(4)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_inv    (in_inv8),
        .in_tag    (in_tag8),
        .state_in  (state_in8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_tag   (out_tag8),
        .state_out (state_out8),
        .occupancy (occupancy8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: state as a 4 x nb byte matrix, rows rotated by their offsets.
    // Input/output are right-aligned with byte 0 in the most significant position.
    function automatic logic [255:0] model_sr(input logic [255:0] st, input int nb, input bit inv);
        byte unsigned m [4][8];
        int           sh [4];
        int           nbytes;
        int           src;
        logic [255:0] res;
        nbytes = 4 * nb;
        res    = '0;
        if (nb == 8) sh = '{0, 1, 3, 4};
        else         sh = '{0, 1, 2, 3};
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = st[8*(nbytes-1-(4*c+r)) +: 8];
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
                res[8*(nbytes-1-(4*c+r)) +: 8] = m[r][src];
            end
        return res;
    endfunction

    typedef struct {
        logic [127:0] st;
        logic [3:0]   tag;
    } exp_t;

    exp_t         q[$];
    int           occ_m     = 0;
    int           delivered = 0;
    bit           prev_stall = 0;
    logic [127:0] prev_st;
    logic [3:0]   prev_tag;

    // Scoreboard: one pass per cycle at the falling edge, inputs are stable then.
    always @(negedge clk) begin
        exp_t         e;
        logic [255:0] mres;
        if (!rst_n) begin
            q.delete();
            occ_m      = 0;
            prev_stall = 0;
        end else begin
            chk("occupancy", 256'(occupancy), 256'(occ_m));
            chk("occupancy_bound", 256'(occupancy <= PS), 256'(1));
            if (prev_stall) begin
                chk("stall_valid", 256'(out_valid), 256'(1));
                chk("stall_data", 256'(state_out), 256'(prev_st));
                chk("stall_tag", 256'(out_tag), 256'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 256'(out_valid), 256'(0));
                end else begin
                    e = q.pop_front();
                    chk("out_data", 256'(state_out), 256'(e.st));
                    chk("out_tag", 256'(out_tag), 256'(e.tag));
                    delivered++;
                    occ_m--;
                end
            end
            if (in_valid && in_ready) begin
                mres  = model_sr(256'(state_in), 4, in_inv);
                e.st  = mres[127:0];
                e.tag = in_tag;
                q.push_back(e);
                occ_m++;
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_st    = state_out;
            prev_tag   = out_tag;
            if (flush) begin
                q.delete();
                occ_m = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one transaction and return just after the edge that accepted it.
    task automatic send(input logic [127:0] st, input logic inv, input logic [3:0] tag);
        bit ok;
        ok       = 0;
        in_valid = 1'b1;
        state_in = st;
        in_inv   = inv;
        in_tag   = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 256'(in_ready), 256'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) tick();
        chk("drain", 256'(q.size()), 256'(0));
    endtask

    logic [127:0] vec_a;
    logic [127:0] vec_b;
    logic [255:0] vec8_in;
    logic [255:0] vec8_out;
    logic [255:0] o8;
    int           d0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_a    = 128'hd42711aee0bf98f1b8b45de51e415230;
        vec_b    = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        vec8_in  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        vec8_out = 256'h00050e13040912170_80d161b0c111a1f10151e031419020718_1d060b1c010a0f;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_tag = '0; state_in = '0;
        drv_ready = 1'b1;
        flush8 = 1'b0; in_valid8 = 1'b0; in_inv8 = 1'b0; in_tag8 = '0; state_in8 = '0;
        out_ready8 = 1'b1;
        #12;
        chk("reset_in_ready", 256'(in_ready), 256'(1));
        chk("reset_out_valid", 256'(out_valid), 256'(0));
        chk("reset_occupancy", 256'(occupancy), 256'(0));
        chk("reset_state_out", 256'(state_out), 256'(0));
        chk("reset_out_tag", 256'(out_tag), 256'(0));
        rst_n = 1'b1;
        tick();
        chk("post_reset_in_ready", 256'(in_ready), 256'(1));
        chk("post_reset_out_valid", 256'(out_valid), 256'(0));

        // Pin the reference model to hand-computed vectors.
        chk("model_fwd4", model_sr(256'(vec_a), 4, 0), 256'(vec_b));
        chk("model_inv4", model_sr(256'(vec_b), 4, 1), 256'(vec_a));
        chk("model_fwd8", model_sr(vec8_in, 8, 0), vec8_out);
        chk("model_rt8", model_sr(vec8_out, 8, 1), vec8_in);

        // 1. forward, latency PS
        send(vec_a, 1'b0, 4'd1);
        for (int i = 1; i < PS; i++) begin
            chk("fwd_latency_early", 256'(out_valid), 256'(0));
            tick();
        end
        chk("fwd_latency", 256'(out_valid), 256'(1));
        chk("fwd_data", 256'(state_out), 256'(vec_b));
        chk("fwd_tag", 256'(out_tag), 256'(1));
        tick();

        // 2. inverse, round trip back to the forward input
        send(vec_b, 1'b1, 4'd2);
        for (int i = 1; i < PS; i++) begin
            chk("inv_latency_early", 256'(out_valid), 256'(0));
            tick();
        end
        chk("inv_latency", 256'(out_valid), 256'(1));
        chk("inv_data", 256'(state_out), 256'(vec_a));
        chk("inv_tag", 256'(out_tag), 256'(2));
        tick();

        // 3. NB=8 forward on a single-stage instance
        in_valid8 = 1'b1; state_in8 = vec8_in; in_inv8 = 1'b0; in_tag8 = 4'd5;
        @(negedge clk);
        chk("nb8_in_ready", 256'(in_ready8), 256'(1));
        tick();
        in_valid8 = 1'b0;
        o8 = state_out8;
        chk("nb8_valid", 256'(out_valid8), 256'(1));
        chk("nb8_data", o8, vec8_out);
        chk("nb8_row2_col0", 256'(o8[255-16 -: 8]), 256'(8'h0e));
        chk("nb8_row3_col0", 256'(o8[255-24 -: 8]), 256'(8'h13));
        chk("nb8_tag", 256'(out_tag8), 256'(5));
        chk("nb8_occupancy", 256'(occupancy8), 256'(1));
        tick();
        chk("nb8_drained", 256'(out_valid8), 256'(0));

        // 4. backpressure stream with alternating direction
        rand_rdy = 1'b1;
        for (int t = 0; t < 8; t++) begin
            send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'(t % 2), 4'(t));
        end
        rand_rdy  = 1'b0;
        drv_ready = 1'b1;
        drain();

        // 5. full pipe, then a single-cycle downstream pulse
        drv_ready = 1'b0;
        tick();
        send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 4'd8);
        send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 4'd9);
        chk("full_occupancy", 256'(occupancy), 256'(PS));
        chk("full_in_ready", 256'(in_ready), 256'(0));
        in_valid = 1'b1;
        state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_inv   = 1'b0;
        in_tag   = 4'd10;
        @(negedge clk);
        chk("full_in_ready_held", 256'(in_ready), 256'(0));
        tick();
        d0        = delivered;
        drv_ready = 1'b1;
        @(negedge clk);
        chk("pulse_in_ready", 256'(in_ready), 256'(1));
        chk("pulse_out_valid", 256'(out_valid), 256'(1));
        tick();
        drv_ready = 1'b0;
        in_valid  = 1'b0;
        chk("pulse_occupancy", 256'(occupancy), 256'(PS));
        tick();
        chk("pulse_one_output", 256'(delivered - d0), 256'(1));
        drv_ready = 1'b1;
        drain();

        // 6a. asynchronous reset mid-stream
        drv_ready = 1'b0;
        send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 4'd3);
        send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 4'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("areset_out_valid", 256'(out_valid), 256'(0));
        chk("areset_occupancy", 256'(occupancy), 256'(0));
        chk("areset_in_ready", 256'(in_ready), 256'(1));
        #4 rst_n = 1'b1;
        drv_ready = 1'b1;
        tick();
        tick();
        chk("areset_stays_empty", 256'(out_valid), 256'(0));

        // 6b. flush mid-stream with a concurrent input offer
        drv_ready = 1'b0;
        send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 4'd6);
        send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 4'd7);
        flush    = 1'b1;
        in_valid = 1'b1;
        state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_tag   = 4'd11;
        @(negedge clk);
        chk("flush_in_ready", 256'(in_ready), 256'(0));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occupancy", 256'(occupancy), 256'(0));
        chk("flush_out_valid", 256'(out_valid), 256'(0));
        drv_ready = 1'b1;
        repeat (4) tick();
        chk("flush_dropped", 256'(out_valid), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
